ibexc_dmem_responder: RTL
=========================

# ibexc_dmem_responder

Responder (memory-side) end of the CHERIoT Ibex data memory interface: accepts the core's `data_req`/`data_gnt` transactions, backs them with a word-addressed 33-bit store (bit 32 = capability tag), and returns in-order `data_rvalid` responses after a fixed latency. It is the simulation and FPGA-bring-up data memory attached directly to `ibexc_top` / `ibexc_top_tracing` data ports. It enforces tag-clearing rules on stores and flags out-of-range accesses.

## Interface
- `AddrBase`, 32'h2000_0000, byte address of word 0
- `MemWords`, 16384, store depth in 33-bit words (power of two)
- `RespLatency`, 1, cycles from grant to `rvalid`; legal 1..4
- `DataWidth`, 33, data width incl. tag; fixed at 33
- `clk_i  in  1  clock`
- `rst_ni  in  1  reset; asynchronous, active-low`
- `data_req_i  in  1  request valid`
- `data_gnt_o  out  1  request accepted this cycle`
- `data_we_i  in  1  1 = store`
- `data_be_i  in  4  byte enables`
- `data_addr_i  in  32  byte address; [1:0] ignored`
- `data_is_cap_i  in  1  word belongs to a capability access`
- `data_wdata_i  in  33  store data; [32] = tag`
- `data_wdata_intg_i  in  7  store-data integrity`
- `data_rvalid_o  out  1  response valid`
- `data_rdata_o  out  33  load data; [32] = tag`
- `data_rdata_intg_o  out  7  load-data integrity`
- `data_err_o  out  1  response is an error`

## Operation
- `data_gnt_o = data_req_i` (combinational); one transaction accepted per cycle, no backpressure.
- Index = (addr − AddrBase) >> 2; in range iff addr ≥ AddrBase and index < MemWords. Subtraction is 32-bit unsigned; wrap below AddrBase counts as out of range.
- Out of range: no store update; response `err=1`, rdata = 0.
- Store, in range: bytes with `be[i]=1` written. Tag: written with `wdata[32]` only when `is_cap_i=1` and `be=4'hF`; otherwise tag cleared to 0 (any non-capability or partial store kills the tag).
- Load, in range: rdata = stored word, tag included unconditionally; `be` does not mask read data.
- Store responses: `rvalid=1`, rdata = 0, err per range/integrity check.
- Load issued the cycle after a store to the same word returns post-store data (store commits at grant edge).
- Tag array resets to all-zero asynchronously; data array not reset (contents X after power-up).

## Timing
- Transaction granted at edge N → response at edge N+RespLatency; responses strictly in grant order; back-to-back grants give back-to-back `rvalid`.
- Load data sampled from store at grant edge, carried through response pipeline.
- Reset values: `data_rvalid_o=0`, `data_rdata_o=0`, `data_err_o=0`, `data_rdata_intg_o` = integrity of zero (macro on) or 0 (off).
- Reset asserted mid-operation: all in-flight responses dropped, no `rvalid` for them; stores already granted remain committed except tags (cleared).
- Outputs other than `data_gnt_o` are registered; when `rvalid=0`, rdata/err/intg held at 0.

## Configuration
- `IBEXC_DMEM_INTG_EN` defined: `data_rdata_intg_o` = inverted SECDED(39,32) check bits of `data_rdata_o[31:0]`; store with `data_wdata_intg_i` ≠ computed check bits of `wdata[31:0]` is not committed and responds `err=1`.
- Undefined: `data_rdata_intg_o` tied 0, `data_wdata_intg_i` ignored, no integrity errors.

## Structure
- Package `ibexc_dmem_pkg`: response-entry struct (valid, err, rdata[32:0]), `RespLatencyMax = 4`, tag-bit index constant 32.
- Sub-module `ibexc_dmem_resp_pipe`: RespLatency-deep shift pipeline of response entries with async reset and integrity generation at its output.

## Test plan
- Store 32'hDEAD_BEEF, tag 1, is_cap=1, be=F to AddrBase+8; load it → rdata 33'h1_DEAD_BEEF after RespLatency cycles, err=0.
- Same word, store be=4'b0001 data 8'h55 → reload gives 33'h0_DEAD_BE55 (tag cleared); full-word store with is_cap=0 and tag=1 → tag reads 0.
- Load at AddrBase−4 and AddrBase+4·MemWords → err=1, rdata=0, store unchanged.
- RespLatency=3, 6 back-to-back alternating store/loads → 6 consecutive in-order `rvalid`, each load returning the prior store's value.
- Assert rst_ni with 2 responses in flight → no `rvalid` after release; previously tagged word now reads tag 0.
- With `IBEXC_DMEM_INTG_EN`: store with flipped intg bit 0 → err=1, word unchanged; load of 0 → rdata_intg equals encoder output for 32'h0.

Source files
------------

// File: rtl/ibexc_dmem_pkg.sv
// Shared types and helpers for the CHERIoT data-memory responder.
// Holds the response-entry bundle and the store-data integrity encoder.
package ibexc_dmem_pkg;

  localparam int unsigned RespLatencyMax = 4;
  localparam int unsigned TagBit         = 32;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [32:0] rdata;
  } resp_t;

  // Inverted Hsiao SECDED(39,32) check bits of a 32-bit word.
  function automatic logic [6:0] intg_enc(input logic [31:0] d);
    logic [6:0] c;
    c[0] = ^(d & 32'h2606_BD25);
    c[1] = ^(d & 32'hDEBA_8050);
    c[2] = ^(d & 32'h413D_89AA);
    c[3] = ^(d & 32'h3123_4ED1);
    c[4] = ^(d & 32'hC2C1_323B);
    c[5] = ^(d & 32'h2DCC_624C);
    c[6] = ^(d & 32'h9850_5586);
    return c ^ 7'h2A;
  endfunction

endpackage

// File: rtl/ibexc_dmem_resp_pipe.sv
// Fixed-depth response shift pipeline with registered integrity output.
// Integrity generation enabled by IBEXC_DMEM_INTG_EN.
module ibexc_dmem_resp_pipe
  import ibexc_dmem_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  resp_t      in_i,
  output resp_t      out_o,
  output logic [6:0] intg_o
);

`ifdef IBEXC_DMEM_INTG_EN
  localparam logic [6:0] IntgRst = intg_enc(32'h0);
`else
  localparam logic [6:0] IntgRst = 7'h0;
`endif

  resp_t      stage_q [Depth];
  resp_t      stage_d [Depth];
  logic [6:0] intg_q;
  logic [6:0] intg_d;

  always_comb begin
    stage_d[0] = in_i;
    for (int i = 1; i < Depth; i++) begin
      stage_d[i] = stage_q[i-1];
    end
`ifdef IBEXC_DMEM_INTG_EN
    intg_d = intg_enc(stage_d[Depth-1].rdata[31:0]);
`else
    intg_d = 7'h0;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        stage_q[i] <= '0;
      end
      intg_q <= IntgRst;
    end else begin
      for (int i = 0; i < Depth; i++) begin
        stage_q[i] <= stage_d[i];
      end
      intg_q <= intg_d;
    end
  end

  assign out_o  = stage_q[Depth-1];
  assign intg_o = intg_q;

endmodule

// File: rtl/ibexc_dmem_responder.sv
// Memory-side responder for the CHERIoT Ibex data port (33-bit tagged words).
// Optional integrity checking/generation with IBEXC_DMEM_INTG_EN.
module ibexc_dmem_responder
  import ibexc_dmem_pkg::*;
#(
  parameter logic [31:0] AddrBase    = 32'h2000_0000,
  parameter int unsigned MemWords    = 16384,
  parameter int unsigned RespLatency = 1,
  parameter int unsigned DataWidth   = 33
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 data_req_i,
  output logic                 data_gnt_o,
  input  logic                 data_we_i,
  input  logic [3:0]           data_be_i,
  input  logic [31:0]          data_addr_i,
  input  logic                 data_is_cap_i,
  input  logic [DataWidth-1:0] data_wdata_i,
  input  logic [6:0]           data_wdata_intg_i,
  output logic                 data_rvalid_o,
  output logic [DataWidth-1:0] data_rdata_o,
  output logic [6:0]           data_rdata_intg_o,
  output logic                 data_err_o
);

  localparam int unsigned IdxW  = $clog2(MemWords);
  localparam int unsigned Depth =
    (RespLatency > RespLatencyMax) ? RespLatencyMax :
    (RespLatency == 0) ? 1 : RespLatency;

  logic [31:0]         mem_q [MemWords];
  logic [MemWords-1:0] tag_q;

  logic [31:0]   off;
  logic [IdxW-1:0] idx;
  logic          in_range;
  logic          intg_err;
  logic          commit;
  logic          tag_wr;
  resp_t         resp_d;
  resp_t         resp_q;

  assign data_gnt_o = data_req_i;

  always_comb begin
    off      = data_addr_i - AddrBase;
    idx      = off[IdxW+1:2];
    in_range = (data_addr_i >= AddrBase) &&
               ({2'b00, off[31:2]} < 32'(MemWords));
`ifdef IBEXC_DMEM_INTG_EN
    intg_err = data_we_i &&
               (data_wdata_intg_i != intg_enc(data_wdata_i[31:0]));
`else
    intg_err = 1'b0;
`endif
    commit = data_req_i & data_we_i & in_range & ~intg_err;
    // Any partial or non-capability store kills the tag.
    tag_wr = data_is_cap_i & (data_be_i == 4'hF) &
             data_wdata_i[TagBit];
    resp_d       = '0;
    resp_d.valid = data_req_i;
    resp_d.err   = data_req_i & (~in_range | intg_err);
    if (data_req_i && !data_we_i && in_range) begin
      resp_d.rdata = {tag_q[idx], mem_q[idx]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be_i[b]) begin
          mem_q[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_q <= '0;
    end else if (commit) begin
      tag_q[idx] <= tag_wr;
    end
  end

  ibexc_dmem_resp_pipe #(
    .Depth (Depth)
  ) u_pipe (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .in_i   (resp_d),
    .out_o  (resp_q),
    .intg_o (data_rdata_intg_o)
  );

  assign data_rvalid_o = resp_q.valid;
  assign data_err_o    = resp_q.err;
  assign data_rdata_o  = resp_q.rdata;

  logic unused_bits;
  assign unused_bits = ^{off[1:0], data_wdata_intg_i};

endmodule
